// File: rtl/decode_feed_if.sv
// Bundle between the wavepool instruction buffers, the decode stage and the feed arbiter.
// The slave modport is the arbiter's view; master is the wavepool/decode side.
interface decode_feed_if #(
    parameter int NUM_WF = 40,
    parameter int WFID_W = 6
);
    logic [NUM_WF-1:0] wf_instr_ready;
    logic [NUM_WF-1:0] wf_clear;
    logic              decode_stall;
    logic              wave_ins_half_rqd;
    logic [WFID_W-1:0] wave_ins_half_wfid;
    logic              issue_valid;
    logic [WFID_W-1:0] issue_wfid;
    logic              arb_valid;
    logic [WFID_W-1:0] arb_wfid;
    logic              arb_second_half;
    logic [NUM_WF-1:0] inflight_mask;
    logic              arb_half_wait;

    modport master (
        output wf_instr_ready, wf_clear, decode_stall, wave_ins_half_rqd,
               wave_ins_half_wfid, issue_valid, issue_wfid,
        input  arb_valid, arb_wfid, arb_second_half, inflight_mask, arb_half_wait
    );

    modport slave (
        input  wf_instr_ready, wf_clear, decode_stall, wave_ins_half_rqd,
               wave_ins_half_wfid, issue_valid, issue_wfid,
        output arb_valid, arb_wfid, arb_second_half, inflight_mask, arb_half_wait
    );
endinterface

// File: rtl/decode_feed_arbiter.sv
// Picks which wavefront feeds decode each cycle: round-robin over ready, not-in-flight
// wavefronts, with an exclusive HALF state that feeds the second dword of long instructions.
//
// state  | meaning
// S_RUN  | normal round-robin first-dword grants
// S_HALF | waiting to feed the second dword of half_wfid; no other grants
module decode_feed_arbiter #(
    parameter int NUM_WF = 40,
    parameter int WFID_W = 6
) (
    input logic         clk,
    input logic         rst,
    decode_feed_if.slave bus
);
    typedef enum logic {S_RUN, S_HALF} state_t;

    state_t            state, state_next;
    logic [WFID_W-1:0] ptr, ptr_next;
    logic [WFID_W-1:0] half_wfid, half_wfid_next;
    logic [NUM_WF-1:0] inflight, inflight_next;
    logic [NUM_WF-1:0] eligible, retire, grant_set;
    logic              valid_q, valid_next;
    logic [WFID_W-1:0] wfid_q, wfid_next;
    logic              second_q, second_next;
    logic              found;
    logic [WFID_W-1:0] sel, cand;
    logic [WFID_W:0]   idx;
    logic              issue_ok, half_ok;

    assign issue_ok = bus.issue_valid && ({1'b0, bus.issue_wfid} < (WFID_W+1)'(NUM_WF));
    assign half_ok  = bus.wave_ins_half_rqd &&
                      ({1'b0, bus.wave_ins_half_wfid} < (WFID_W+1)'(NUM_WF));
    assign eligible = bus.wf_instr_ready & ~inflight & ~bus.wf_clear;

    // first eligible slot at or after ptr, wrapping at NUM_WF
    always_comb begin : rr_search
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_WF; k++) begin
            idx = {1'b0, ptr} + (WFID_W+1)'(k);
            if (idx >= (WFID_W+1)'(NUM_WF))
                idx = idx - (WFID_W+1)'(NUM_WF);
            cand = idx[WFID_W-1:0];
            if (!found && eligible[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin : fsm_next
        state_next     = state;
        ptr_next       = ptr;
        half_wfid_next = half_wfid;
        valid_next     = 1'b0;
        wfid_next      = '0;
        second_next    = 1'b0;
        grant_set      = '0;
        retire         = bus.wf_clear;
        if (issue_ok)
            retire[bus.issue_wfid] = 1'b1;
        case (state)
            S_RUN: begin
                if (half_ok) begin
                    state_next     = S_HALF;
                    half_wfid_next = bus.wave_ins_half_wfid;
                end else if (!bus.decode_stall && found) begin
                    valid_next     = 1'b1;
                    wfid_next      = sel;
                    grant_set[sel] = 1'b1;
                    ptr_next       = (sel == WFID_W'(NUM_WF-1)) ? '0 : sel + WFID_W'(1);
                end
            end
            S_HALF: begin
                if (bus.wf_clear[half_wfid]) begin
                    state_next = S_RUN;
                end else if (bus.wf_instr_ready[half_wfid] && !bus.decode_stall) begin
                    valid_next  = 1'b1;
                    wfid_next   = half_wfid;
                    second_next = 1'b1;
                    state_next  = S_RUN;
                end
            end
            default: state_next = S_RUN;
        endcase
        // a retire in the grant cycle lands first; the new grant's set wins
        inflight_next = (inflight & ~retire) | grant_set;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_RUN;
            ptr       <= '0;
            half_wfid <= '0;
            inflight  <= '0;
            valid_q   <= 1'b0;
            wfid_q    <= '0;
            second_q  <= 1'b0;
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            half_wfid <= half_wfid_next;
            inflight  <= inflight_next;
            valid_q   <= valid_next;
            wfid_q    <= wfid_next;
            second_q  <= second_next;
        end
    end

    assign bus.arb_valid       = valid_q;
    assign bus.arb_wfid        = wfid_q;
    assign bus.arb_second_half = second_q;
    assign bus.inflight_mask   = inflight;
    assign bus.arb_half_wait   = (state == S_HALF);
endmodule

// File: tb/tb_decode_feed_arbiter.sv
// Self-checking bench for decode_feed_arbiter: directed table, corner sequences,
// and random traffic compared against a behavioural scheduling model.
module tb_decode_feed_arbiter;
    localparam int NUM_WF = 40;
    localparam int WFID_W = 6;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    decode_feed_if #(.NUM_WF(NUM_WF), .WFID_W(WFID_W)) bus ();

    decode_feed_arbiter #(.NUM_WF(NUM_WF), .WFID_W(WFID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // behavioural model state
    bit m_infl[NUM_WF];
    int m_ptr;
    bit m_half;
    int m_hid;
    bit m_valid;
    int m_wfid;
    bit m_h2;

    typedef struct {
        logic [NUM_WF-1:0] ready;
        logic              stall;
        logic              hrq;
        logic [WFID_W-1:0] hwfid;
        logic              iv;
        logic [WFID_W-1:0] iwfid;
        logic              e_valid;
        logic [WFID_W-1:0] e_wfid;
        logic              e_h2;
        logic              e_hw;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input logic [NUM_WF-1:0] r, input int s, input int h, input int hw,
                                input int iv, input int iw, input int ev, input int ew,
                                input int eh2, input int ehw);
        vec_t v;
        v.ready   = r;
        v.stall   = (s != 0);
        v.hrq     = (h != 0);
        v.hwfid   = WFID_W'(hw);
        v.iv      = (iv != 0);
        v.iwfid   = WFID_W'(iw);
        v.e_valid = (ev != 0);
        v.e_wfid  = WFID_W'(ew);
        v.e_h2    = (eh2 != 0);
        v.e_hw    = (ehw != 0);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_mask();
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < NUM_WF; i++) r[i] = m_infl[i];
        return r;
    endfunction

    // advance the model by one clock using the inputs currently driven
    task automatic model_update();
        bit clr[NUM_WF];
        int g;
        int i;
        g = -1;
        if (!rst) begin
            for (int j = 0; j < NUM_WF; j++) m_infl[j] = 0;
            m_ptr = 0; m_half = 0; m_hid = 0; m_valid = 0; m_wfid = 0; m_h2 = 0;
            return;
        end
        for (int j = 0; j < NUM_WF; j++) clr[j] = bus.wf_clear[j];
        if (bus.issue_valid && int'(bus.issue_wfid) < NUM_WF) clr[int'(bus.issue_wfid)] = 1;
        m_valid = 0; m_wfid = 0; m_h2 = 0;
        if (m_half) begin
            if (bus.wf_clear[m_hid]) begin
                m_half = 0;
            end else if (bus.wf_instr_ready[m_hid] && !bus.decode_stall) begin
                m_valid = 1; m_wfid = m_hid; m_h2 = 1; m_half = 0;
            end
        end else if (bus.wave_ins_half_rqd && int'(bus.wave_ins_half_wfid) < NUM_WF) begin
            m_half = 1;
            m_hid  = int'(bus.wave_ins_half_wfid);
        end else if (!bus.decode_stall) begin
            for (int k = 0; k < NUM_WF; k++) begin
                i = (m_ptr + k) % NUM_WF;
                if (g < 0 && bus.wf_instr_ready[i] && !m_infl[i] && !bus.wf_clear[i]) g = i;
            end
            if (g >= 0) begin
                m_valid = 1; m_wfid = g; m_ptr = (g + 1) % NUM_WF;
            end
        end
        for (int j = 0; j < NUM_WF; j++) if (clr[j]) m_infl[j] = 0;
        if (g >= 0) m_infl[g] = 1;
    endtask

    task automatic compare_model();
        check("valid", 64'(bus.arb_valid), 64'(m_valid));
        if (m_valid) check("wfid", 64'(bus.arb_wfid), 64'(m_wfid));
        check("second_half", 64'(bus.arb_second_half), 64'(m_h2));
        check("half_wait", 64'(bus.arb_half_wait), 64'(m_half));
        check("inflight", 64'(bus.inflight_mask), model_mask());
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic idle_inputs();
        bus.wf_instr_ready     = '0;
        bus.wf_clear           = '0;
        bus.decode_stall       = 1'b0;
        bus.wave_ins_half_rqd  = 1'b0;
        bus.wave_ins_half_wfid = '0;
        bus.issue_valid        = 1'b0;
        bus.issue_wfid         = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        step();
        check("rst_valid", 64'(bus.arb_valid), 64'd0);
        check("rst_mask", 64'(bus.inflight_mask), 64'd0);
        rst = 1'b1;
    endtask

    task automatic expect_grant(input string name, input int ev, input int ew, input int eh2);
        check({name, "_valid"}, 64'(bus.arb_valid), 64'(ev));
        if (ev != 0) check({name, "_wfid"}, 64'(bus.arb_wfid), 64'(ew));
        check({name, "_h2"}, 64'(bus.arb_second_half), 64'(eh2));
    endtask

    initial begin
        logic [63:0] r64;
        n_checks = 0;
        n_fail   = 0;
        clk      = 1'b0;
        rst      = 1'b0;
        idle_inputs();

        tbl[0]  = mk(40'h7, 0, 0, 0, 0, 0,  1, 0, 0, 0);
        tbl[1]  = mk(40'h7, 0, 0, 0, 0, 0,  1, 1, 0, 0);
        tbl[2]  = mk(40'h7, 0, 0, 0, 0, 0,  1, 2, 0, 0);
        tbl[3]  = mk(40'h7, 0, 0, 0, 1, 0,  0, 0, 0, 0);
        tbl[4]  = mk(40'h7, 0, 0, 0, 1, 1,  1, 0, 0, 0);
        tbl[5]  = mk(40'h7, 0, 0, 0, 1, 2,  1, 1, 0, 0);
        tbl[6]  = mk(40'h7, 0, 0, 0, 0, 0,  1, 2, 0, 0);
        tbl[7]  = mk(40'h7, 1, 0, 0, 1, 0,  0, 0, 0, 0);
        tbl[8]  = mk(40'h7, 1, 0, 0, 0, 0,  0, 0, 0, 0);
        tbl[9]  = mk(40'h7, 0, 0, 0, 0, 0,  1, 0, 0, 0);
        tbl[10] = mk(40'h0, 0, 1, 0, 0, 0,  0, 0, 0, 1);
        tbl[11] = mk(40'h0, 0, 0, 0, 0, 0,  0, 0, 0, 1);
        tbl[12] = mk(40'h1, 1, 0, 0, 0, 0,  0, 0, 0, 1);
        tbl[13] = mk(40'h1, 0, 0, 0, 0, 0,  1, 0, 1, 0);
        tbl[14] = mk(40'h0, 0, 0, 0, 1, 0,  0, 0, 0, 0);
        tbl[15] = mk(40'h2, 0, 0, 0, 1, 45, 0, 0, 0, 0);
        tbl[16] = mk(40'h2, 0, 0, 0, 1, 1,  0, 0, 0, 0);
        tbl[17] = mk(40'h2, 0, 0, 0, 0, 0,  1, 1, 0, 0);

        do_reset();
        for (int i = 0; i < 18; i++) begin
            bus.wf_instr_ready     = tbl[i].ready;
            bus.decode_stall       = tbl[i].stall;
            bus.wave_ins_half_rqd  = tbl[i].hrq;
            bus.wave_ins_half_wfid = tbl[i].hwfid;
            bus.issue_valid        = tbl[i].iv;
            bus.issue_wfid         = tbl[i].iwfid;
            step();
            check($sformatf("tbl%0d_valid", i), 64'(bus.arb_valid), 64'(tbl[i].e_valid));
            if (tbl[i].e_valid) check($sformatf("tbl%0d_wfid", i), 64'(bus.arb_wfid), 64'(tbl[i].e_wfid));
            check($sformatf("tbl%0d_h2", i), 64'(bus.arb_second_half), 64'(tbl[i].e_h2));
            check($sformatf("tbl%0d_hw", i), 64'(bus.arb_half_wait), 64'(tbl[i].e_hw));
        end
        idle_inputs();

        // wrap-around, then long instruction on wfid 5
        do_reset();
        bus.wf_instr_ready = 40'h1 << 37;
        step(); expect_grant("wrap37", 1, 37, 0);
        bus.wf_instr_ready = '0; bus.issue_valid = 1'b1; bus.issue_wfid = 6'd37;
        step(); expect_grant("wrap_idle", 0, 0, 0);
        bus.issue_valid = 1'b0;
        bus.wf_instr_ready = (40'h1 << 39) | (40'h1 << 3);
        step(); expect_grant("wrap39", 1, 39, 0);
        step(); expect_grant("wrap3", 1, 3, 0);
        bus.wf_instr_ready = (40'h1 << 2) | (40'h1 << 5);
        step(); expect_grant("ptr4", 1, 5, 0);
        bus.wf_instr_ready = '0; bus.wave_ins_half_rqd = 1'b1; bus.wave_ins_half_wfid = 6'd5;
        step(); check("long_enter_hw", 64'(bus.arb_half_wait), 64'd1);
        bus.wave_ins_half_rqd = 1'b0;
        bus.wf_instr_ready = (40'h1 << 2);
        for (int i = 0; i < 4; i++) begin
            step();
            check("long_wait_hw", 64'(bus.arb_half_wait), 64'd1);
            expect_grant("long_wait", 0, 0, 0);
        end
        bus.wf_instr_ready = (40'h1 << 5);
        step(); expect_grant("long_h2", 1, 5, 1);
        check("long_exit_hw", 64'(bus.arb_half_wait), 64'd0);
        idle_inputs();
        step();

        // stall, then clear during HALF
        do_reset();
        bus.wf_instr_ready = 40'h1 << 7; bus.decode_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); expect_grant("stall", 0, 0, 0);
        end
        bus.decode_stall = 1'b0;
        step(); expect_grant("stall_release", 1, 7, 0);
        bus.wf_instr_ready = 40'h1 << 9;
        step(); expect_grant("grant9", 1, 9, 0);
        bus.wf_instr_ready = '0; bus.wave_ins_half_rqd = 1'b1; bus.wave_ins_half_wfid = 6'd9;
        step(); bus.wave_ins_half_rqd = 1'b0;
        step(); check("clr_half_hw", 64'(bus.arb_half_wait), 64'd1);
        bus.wf_clear = 40'h1 << 9;
        step();
        check("clr_abort_hw", 64'(bus.arb_half_wait), 64'd0);
        check("clr_infl9", 64'(bus.inflight_mask[9]), 64'd0);
        expect_grant("clr_abort", 0, 0, 0);
        bus.wf_clear = '0;
        for (int i = 0; i < 3; i++) begin
            step(); check("clr_no_h2", 64'(bus.arb_second_half), 64'd0);
        end

        // reset in the middle of HALF
        do_reset();
        bus.wf_instr_ready = 40'hF;
        for (int i = 0; i < 4; i++) step();
        bus.wf_instr_ready = '0; bus.wave_ins_half_rqd = 1'b1; bus.wave_ins_half_wfid = 6'd2;
        step();
        check("mid_mask", 64'(bus.inflight_mask), 64'hF);
        check("mid_hw", 64'(bus.arb_half_wait), 64'd1);
        rst = 1'b0;
        step();
        expect_grant("mid_rst", 0, 0, 0);
        check("mid_rst_hw", 64'(bus.arb_half_wait), 64'd0);
        check("mid_rst_mask", 64'(bus.inflight_mask), 64'd0);
        check("mid_rst_wfid", 64'(bus.arb_wfid), 64'd0);
        rst = 1'b1;
        bus.wave_ins_half_rqd = 1'b0;
        bus.wf_instr_ready = (40'h1 << 1) | (40'h1 << 3);
        step(); expect_grant("mid_first", 1, 1, 0);

        // random traffic against the model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            r64 = {$urandom, $urandom};
            bus.wf_instr_ready = NUM_WF'(r64) & NUM_WF'({$urandom, $urandom});
            bus.wf_clear = '0;
            if ($urandom_range(0, 19) == 0) bus.wf_clear[$urandom_range(0, NUM_WF-1)] = 1'b1;
            bus.decode_stall       = ($urandom_range(0, 4) == 0);
            bus.wave_ins_half_rqd  = ($urandom_range(0, 15) == 0);
            bus.wave_ins_half_wfid = WFID_W'($urandom_range(0, 44));
            if (bus.wave_ins_half_rqd && int'(bus.wave_ins_half_wfid) < NUM_WF)
                bus.wf_clear[int'(bus.wave_ins_half_wfid)] = 1'b0;
            bus.issue_valid = ($urandom_range(0, 2) == 0);
            bus.issue_wfid  = WFID_W'($urandom_range(0, 47));
            rst = ($urandom_range(0, 999) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
